result_dispatch_4ch: RTL and testbench

- Buffered dispatcher that sequences the 16-bit 1-to-4 result demultiplexer in the K_ALU datapath.
- Accepts tagged 16-bit results from the ALU writeback side through a valid/ready handshake and queues them in a small FIFO.
- Drives the demux select and the shared 16-bit data bus, and handshakes with each of the 4 destination channels.
- A per-transfer watchdog drops results whose destination stalls too long, so a dead consumer cannot lock up the ALU.

---
 rtl/result_dispatch_4ch.sv | 148 ++++++++++++++
 tb/tb_result_dispatch_4ch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_dispatch_4ch.sv
// result_dispatch_4ch: buffered dispatcher for the 16-bit 1-to-4 result demux.
// Tagged results enter a small FIFO through a valid/ready handshake. They are
// then presented one at a time on a shared bus with a one-hot per-channel
// valid. A per-transfer watchdog drops a result whose destination stalls.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_valid       result available
//   in_ready       FIFO can accept (not full)
//   in_data        16-bit result word
//   in_dest        2-bit destination channel tag
//   bus_data       shared data driven into the demux input
//   bus_sel        demux select
//   out_valid      one-hot valid, bit k = channel k
//   out_ready      per-channel accept
//   occupancy      FIFO entry count (output register excluded)
//   drop_count     saturating count of timed-out results
//   timeout_pulse  one-cycle pulse after a result is dropped
module result_dispatch_4ch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_data,
    input  logic [1:0]               in_dest,
    output logic [15:0]              bus_data,
    output logic [1:0]               bus_sel,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     timeout_pulse
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH) + 1;
    localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic [1:0]  dest;
        logic [15:0] data;
    } result_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    result_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OW-1:0]   count;
    state_t          state;
    logic [WW-1:0]   watchdog;
    result_t         head;

    logic            full;
    logic            empty;
    logic            push;
    logic            hs;
    logic            expire;
    logic            pop;

    // Handshake, watchdog expiry and FIFO push/pop decisions
    always_comb begin
        full   = (count == OW'(DEPTH));
        empty  = (count == '0);
        push   = in_valid && !full;
        hs     = (state == SEND) && out_ready[bus_sel];
        // A handshake on the expiry cycle wins over the drop
        expire = (state == SEND) && !hs && (TIMEOUT != 0) && (watchdog == WW'(TIMEOUT));
        pop    = !empty && ((state == IDLE) || hs || expire);
        head   = mem[rd_ptr];
    end

    assign in_ready  = !full;
    assign occupancy = count;
    assign out_valid = (state == SEND) ? (4'b0001 << bus_sel) : 4'b0000;

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dest: in_dest, data: in_data};
        end
    end

    // Pointers, occupancy, output stage, watchdog and drop accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= IDLE;
            watchdog      <= '0;
            bus_data      <= '0;
            bus_sel       <= '0;
            drop_count    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + OW'(1);
            end else if (!push && pop) begin
                count <= count - OW'(1);
            end

            timeout_pulse <= expire;
            if (expire && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        bus_data <= head.data;
                        bus_sel  <= head.dest;
                        watchdog <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (hs || expire) begin
                        watchdog <= '0;
                        if (pop) begin
                            bus_data <= head.data;
                            bus_sel  <= head.dest;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (watchdog != '1) begin
                        watchdog <= watchdog + WW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_dispatch_4ch.sv
// Scoreboard bench for result_dispatch_4ch. Accepted writes are queued with
// their acceptance edge. The monitor predicts, from arrival and release times,
// when the head word is on the bus. It also predicts occupancy, drops,
// timeout pulses and the saturating drop counter.
module tb_result_dispatch_4ch;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CNT_W   = 3;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0]            in_data;
    logic [1:0]             in_dest;
    logic [15:0]            bus_data;
    logic [1:0]             bus_sel;
    logic [3:0]             out_valid;
    logic [3:0]             out_ready;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0]       drop_count;
    logic                   timeout_pulse;

    result_dispatch_4ch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .bus_data(bus_data), .bus_sel(bus_sel),
        .out_valid(out_valid), .out_ready(out_ready), .occupancy(occupancy),
        .drop_count(drop_count), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dest;
        logic [15:0] data;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_release = 0;
    int          waited = 0;
    int          exp_drops = 0;
    bit          pulse_exp = 0;
    logic [15:0] last_data = '0;
    logic [1:0]  last_sel = '0;
    bit          pres;
    int          occ;
    int          start;
    logic [3:0]  ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Edge counter and scoreboard push of every accepted write
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            q.push_back('{dest: in_dest, data: in_data, acc: cyc});
        end
    end

    // Monitor: predict presentation, compare, then retire on handshake or drop
    always @(negedge clk) begin
        if (rst_n) begin
            pres = 0;
            if (q.size() > 0) begin
                start = (q[0].acc + 1 > last_release) ? q[0].acc + 1 : last_release;
                pres  = (cyc >= start);
            end
            occ = q.size() - (pres ? 1 : 0);
            chk("occupancy", 32'(occupancy), 32'(occ));
            chk("in_ready", 32'(in_ready), 32'(occ < DEPTH));
            chk("timeout_pulse", 32'(timeout_pulse), 32'(pulse_exp));
            chk("drop_count", 32'(drop_count), 32'(exp_drops));
            if (pres) begin
                ev = 4'b0001 << q[0].dest;
                chk("out_valid", 32'(out_valid), 32'(ev));
                chk("bus_data", 32'(bus_data), 32'(q[0].data));
                chk("bus_sel", 32'(bus_sel), 32'(q[0].dest));
                last_data = q[0].data;
                last_sel  = q[0].dest;
                if (out_ready[q[0].dest]) begin
                    void'(q.pop_front());
                    waited       = 0;
                    last_release = cyc + 1;
                    pulse_exp    = 0;
                end else if (waited == TIMEOUT) begin
                    void'(q.pop_front());
                    waited       = 0;
                    last_release = cyc + 1;
                    pulse_exp    = 1;
                    if (exp_drops < CMAX) exp_drops++;
                end else begin
                    waited++;
                    pulse_exp = 0;
                end
            end else begin
                chk("out_valid_idle", 32'(out_valid), 32'h0);
                chk("bus_data_hold", 32'(bus_data), 32'(last_data));
                chk("bus_sel_hold", 32'(bus_sel), 32'(last_sel));
                pulse_exp = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [1:0] d, input logic [15:0] v);
        in_valid = 1'b1;
        in_dest  = d;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_occupancy", 32'(occupancy), 32'h0);
        chk("reset_drop_count", 32'(drop_count), 32'h0);
        chk("reset_pulse", 32'(timeout_pulse), 32'h0);
        chk("reset_bus_data", 32'(bus_data), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        q.delete();
        waited       = 0;
        last_release = 0;
        exp_drops    = 0;
        pulse_exp    = 0;
        last_data    = '0;
        last_sel     = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int blk;
        int blk_left;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        out_ready = 4'h0;
        step();
        step();
        chk("init_out_valid", 32'(out_valid), 32'h0);
        chk("init_occupancy", 32'(occupancy), 32'h0);
        rst_n = 1'b1;
        step();

        // Single write to channel 2
        out_ready = 4'b0100;
        write1(2'd2, 16'hBEEF);
        repeat (4) step();

        // Back-to-back burst to all channels
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) write1(2'(i), 16'(i + 1));
        repeat (6) step();

        // Fill FIFO plus output register with all channels stalled
        out_ready = 4'h0;
        for (int i = 0; i < 6; i++) write1(2'(i % 4), 16'h1000 + 16'(i));
        chk("full_in_ready", 32'(in_ready), 32'h0);
        chk("full_occupancy", 32'(occupancy), 32'(DEPTH));
        out_ready = 4'hF;
        repeat (8) step();

        // Watchdog drop on channel 1 with a second word queued behind it
        out_ready = 4'h0;
        write1(2'd1, 16'hA001);
        write1(2'd2, 16'hA002);
        repeat (TIMEOUT + 6) step();
        out_ready = 4'b0100;
        repeat (4) step();

        // Handshake on the exact expiry cycle counts as a transfer
        out_ready = 4'h0;
        write1(2'd1, 16'hC0DE);
        for (int i = 0; i < 50 && out_valid == 4'h0; i++) @(negedge clk);
        chk("wait_present", 32'(out_valid != 4'h0), 32'h1);
        repeat (TIMEOUT) @(posedge clk);
        #1;
        out_ready = 4'b0010;
        step();
        out_ready = 4'h0;
        repeat (3) step();

        // Sustained stall drives drop_count into saturation
        in_valid = 1'b1;
        for (int i = 0; i < (CMAX + 3) * (TIMEOUT + 1); i++) begin
            in_dest = 2'($urandom_range(0, 3));
            in_data = 16'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 4'hF;
        repeat (8) step();

        // Reset in the middle of a stalled burst
        out_ready = 4'h0;
        for (int i = 0; i < 4; i++) write1(2'(i), 16'h5500 + 16'(i));
        do_reset();
        repeat (4) step();

        // Randomized traffic with periodic single-channel stalls
        blk      = 0;
        blk_left = 0;
        for (int i = 0; i < 2000; i++) begin
            if (blk_left == 0 && $urandom_range(0, 199) == 0) begin
                blk      = $urandom_range(0, 3);
                blk_left = $urandom_range(20, 60);
            end
            in_valid  = ($urandom_range(0, 2) != 0);
            in_dest   = 2'($urandom_range(0, 3));
            in_data   = 16'($urandom);
            out_ready = 4'($urandom);
            if (blk_left > 0) begin
                out_ready[blk] = 1'b0;
                blk_left--;
            end
            step();
        end

        // Drain
        in_valid  = 1'b0;
        out_ready = 4'hF;
        for (int i = 0; i < 100 && q.size() > 0; i++) step();
        chk("drained", 32'(q.size()), 32'h0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
